// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one magnitude comparator among NREQ
// requesters. Each transaction runs IDLE -> CMP -> RESP. The response carries
// the captured comparator result and the id of the requester that was served.
module cmp_arbiter #(
  parameter int W    = 3,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*W-1:0] i_req_a,
  input  logic [NREQ*W-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [W-1:0]      o_cmp_a,
  output logic [W-1:0]      o_cmp_b,
  input  logic [2:0]        i_cmp_f,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [2:0]        o_rsp_f,
  input  logic              i_rsp_ready,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t         state, next_state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic [W-1:0]   op_a, op_b;
  logic           f_onehot;
  int             idx;

  // Round-robin search: first valid requester strictly after the pointer, with wrap
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic and the combinational grant strobe (only ever in IDLE)
  always_comb begin
    next_state  = state;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          o_req_ready[win] = 1'b1;
          next_state       = CMP;
        end
      end
      CMP:     next_state = RESP;
      RESP:    if (i_rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign f_onehot = (i_cmp_f == 3'b100) || (i_cmp_f == 3'b010) || (i_cmp_f == 3'b001);

  // Datapath: operand capture on grant, result capture in CMP, release and pointer update in RESP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= IDW'(NREQ - 1);
      op_a        <= '0;
      op_b        <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_f     <= '0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a     <= i_req_a[int'(win)*W +: W];
            op_b     <= i_req_b[int'(win)*W +: W];
            o_rsp_id <= win;
          end
        end
        CMP: begin
          o_rsp_f     <= i_cmp_f;
          o_rsp_valid <= 1'b1;
          if (!f_onehot) o_err <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            ptr         <= o_rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

  // The comparator only ever sees registered operands, never the request bus
  assign o_cmp_a = op_a;
  assign o_cmp_b = op_b;
  assign o_busy  = (state != IDLE);

endmodule
